// File: rtl/csr_decoder.sv
// rtl/csr_decoder.sv - CSR to dense raster decoder: pointer load, entry merge, zero fill
module csr_decoder #(
  parameter int word_length        = 8,
  parameter int double_word_length = 16,
  parameter int col_length         = 8,
  parameter int image_size         = 28
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          ptr_valid,
  output logic                          ptr_ready,
  input  logic [double_word_length-1:0] ptr_data,
  input  logic                          ent_valid,
  output logic                          ent_ready,
  input  logic [col_length-1:0]         ent_col,
  input  logic [word_length-1:0]        ent_value,
  output logic                          out_valid,
  output logic [word_length-1:0]        data_out,
  output logic [col_length-1:0]         out_row,
  output logic [col_length-1:0]         out_col,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  // Pointer RAM holds image_size+1 row pointers, indexed 0..image_size.
  localparam int PW = $clog2(image_size + 1);
  localparam logic [double_word_length-1:0] PIX_TOTAL = double_word_length'(image_size * image_size);
  localparam logic [col_length-1:0] LAST_IDX = col_length'(image_size - 1);
  localparam logic [col_length-1:0] EDGE_IDX = col_length'(image_size);
  localparam logic [PW-1:0] PTR_LAST = PW'(image_size);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD_PTR = 2'd1,
    DECODE   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [double_word_length-1:0] ptr_mem_q [0:image_size];
  logic                          ptr_we;

  logic [PW-1:0]                 p_q, p_d;
  logic [double_word_length-1:0] last_ptr_q, last_ptr_d;
  logic [col_length-1:0]         row_q, row_d;
  logic [col_length-1:0]         col_q, col_d;
  logic [double_word_length-1:0] k_q, k_d;
  logic                          err_q, err_d;
  logic                          done_q, done_d;
  logic                          out_valid_q, out_valid_d;
  logic [word_length-1:0]        data_out_q, data_out_d;
  logic [col_length-1:0]         out_row_q, out_row_d;
  logic [col_length-1:0]         out_col_q, out_col_d;

  logic [PW-1:0] nxt_idx;
  logic          pending;
  logic          hit;
  logic          bad;
  logic          emit;
  logic          last_pix;

  // Row r owns entries k in [ptr[r], ptr[r+1]); look up the end bound of the current row.
  assign nxt_idx  = PW'(row_q) + PW'(1);
  assign last_pix = (row_q == LAST_IDX) && (col_q == LAST_IDX);

  // Next-state, handshake and pixel decision logic for all three states.
  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    last_ptr_d  = last_ptr_q;
    row_d       = row_q;
    col_d       = col_q;
    k_d         = k_q;
    err_d       = err_q;
    done_d      = 1'b0;
    out_valid_d = 1'b0;
    data_out_d  = data_out_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    ptr_we      = 1'b0;
    ptr_ready   = 1'b0;
    ent_ready   = 1'b0;
    pending     = 1'b0;
    hit         = 1'b0;
    bad         = 1'b0;
    emit        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_PTR;
          err_d   = 1'b0;
          p_d     = '0;
        end
      end

      LOAD_PTR: begin
        ptr_ready = 1'b1;
        if (ptr_valid) begin
          ptr_we     = 1'b1;
          p_d        = p_q + PW'(1);
          last_ptr_d = ptr_data;
          // Malformed pointer tables are flagged but loading carries on.
          if ((p_q == '0) && (ptr_data != '0)) err_d = 1'b1;
          if ((p_q != '0) && (ptr_data < last_ptr_q)) err_d = 1'b1;
          if ((p_q == PTR_LAST) && (ptr_data > PIX_TOTAL)) err_d = 1'b1;
          if (p_q == PTR_LAST) begin
            state_d = DECODE;
            row_d   = '0;
            col_d   = '0;
            k_d     = '0;
          end
        end
      end

      DECODE: begin
        pending = (k_q < ptr_mem_q[nxt_idx]);
        hit     = pending && ent_valid && (ent_col == col_q);
        bad     = pending && ent_valid && ((ent_col < col_q) || (ent_col >= EDGE_IDX));
        // Rows with nothing pending emit zeros regardless of ent_valid.
        emit    = !pending || ent_valid;
        ent_ready = hit || bad;
        if (hit || bad) k_d = k_q + double_word_length'(1);
        if (bad) err_d = 1'b1;
        if (emit) begin
          out_valid_d = 1'b1;
          data_out_d  = hit ? ent_value : '0;
          out_row_d   = row_q;
          out_col_d   = col_q;
          if (col_q == LAST_IDX) begin
            col_d = '0;
            row_d = row_q + col_length'(1);
          end else begin
            col_d = col_q + col_length'(1);
          end
          if (last_pix) begin
            state_d = IDLE;
            done_d  = 1'b1;
            if (k_d != ptr_mem_q[PTR_LAST]) err_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Pointer RAM write port; contents are only read after a full load, so no reset.
  always_ff @(posedge clk) begin
    if (ptr_we) ptr_mem_q[p_q] <= ptr_data;
  end

  // State, counters and registered outputs; reset aborts any frame in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      p_q         <= '0;
      last_ptr_q  <= '0;
      row_q       <= '0;
      col_q       <= '0;
      k_q         <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      last_ptr_q  <= last_ptr_d;
      row_q       <= row_d;
      col_q       <= col_d;
      k_q         <= k_d;
      err_q       <= err_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;

endmodule

// File: tb/tb_csr_decoder.sv
// tb/tb_csr_decoder.sv - scoreboard bench for csr_decoder
module tb_csr_decoder;
  localparam int N = 28;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        ptr_valid = 1'b0;
  logic        ptr_ready;
  logic [15:0] ptr_data = '0;
  logic        ent_valid = 1'b0;
  logic        ent_ready;
  logic [7:0]  ent_col = '0;
  logic [7:0]  ent_value = '0;
  logic        out_valid;
  logic [7:0]  data_out;
  logic [7:0]  out_row;
  logic [7:0]  out_col;
  logic        busy;
  logic        done;
  logic        err;

  csr_decoder dut (
    .clk(clk), .rst(rst), .start(start),
    .ptr_valid(ptr_valid), .ptr_ready(ptr_ready), .ptr_data(ptr_data),
    .ent_valid(ent_valid), .ent_ready(ent_ready), .ent_col(ent_col), .ent_value(ent_value),
    .out_valid(out_valid), .data_out(data_out), .out_row(out_row), .out_col(out_col),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] row;
    logic [7:0] col;
    logic [7:0] data;
    logic       done;
  } pix_t;

  pix_t exp_q[$];
  pix_t got_e;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int pix_cnt = 0;
  int ready_cnt = 0;
  int first_cyc = -1;
  int exp_span = N * N;

  int         pv [0:N];
  int         ecol[$];
  int         eval[$];
  int         stall_idx = -1;
  logic [7:0] img [0:N-1][0:N-1];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a pixel is presented.
  always @(negedge clk) begin
    if (!rst) begin
      if (ent_ready) ready_cnt++;
      if (done && !out_valid) begin
        checks++; errors++;
        $display("FAIL done_without_valid at cycle %0d", cyc);
      end
      if (out_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        pix_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pixel: got r%0d c%0d d%0h, queue empty", out_row, out_col, data_out);
        end else begin
          got_e = exp_q.pop_front();
          if ({out_row, out_col, data_out, done} !== got_e) begin
            errors++;
            $display("FAIL pixel: got r%0d c%0d d%0h done%b expected r%0d c%0d d%0h done%b",
                     out_row, out_col, data_out, done, got_e.row, got_e.col, got_e.data, got_e.done);
          end
        end
        if (done) begin
          chk("frame_span", cyc - first_cyc + 1, exp_span);
          done_cnt++;
          first_cyc = -1;
        end
      end
    end
  end

  task automatic clear_frame();
    for (int i = 0; i <= N; i++) pv[i] = 0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) img[r][c] = 8'h00;
    ecol.delete();
    eval.delete();
    stall_idx = -1;
  endtask

  task automatic push_expect();
    pix_t e;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        e.row  = 8'(r);
        e.col  = 8'(c);
        e.data = img[r][c];
        e.done = (r == N - 1) && (c == N - 1);
        exp_q.push_back(e);
      end
  endtask

  task automatic load_ptrs();
    for (int i = 0; i <= N; i++) begin
      int t = 0;
      ptr_valid = 1'b1;
      ptr_data  = 16'(pv[i]);
      @(negedge clk);
      while (!ptr_ready && t < 100) begin @(negedge clk); t++; end
      if (!ptr_ready) begin
        chk("ptr_ready_timeout", 32'(ptr_ready), 1);
        ptr_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    ptr_valid = 1'b0;
  endtask

  task automatic feed_ents();
    for (int i = 0; i < ecol.size(); i++) begin
      int t = 0;
      if (i == stall_idx) begin
        ent_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
      end
      ent_valid = 1'b1;
      ent_col   = 8'(ecol[i]);
      ent_value = 8'(eval[i]);
      @(negedge clk);
      while (!ent_ready && t < 3000) begin @(negedge clk); t++; end
      if (!ent_ready) begin
        chk("ent_ready_timeout", 32'(ent_ready), 1);
        ent_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    ent_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_frame(input string nm, input logic exp_err, input int span);
    int base;
    int t;
    push_expect();
    exp_span = span;
    base = done_cnt;
    pulse_start();
    chk({nm, "_busy_after_start"}, 32'(busy), 1);
    chk({nm, "_err_cleared"}, 32'(err), 0);
    fork
      load_ptrs();
      feed_ents();
    join
    t = 0;
    while (done_cnt == base && t < 3000) begin @(negedge clk); t++; end
    chk({nm, "_done_count"}, done_cnt - base, 1);
    @(negedge clk);
    chk({nm, "_busy_idle"}, 32'(busy), 0);
    chk({nm, "_err"}, 32'(err), 32'(exp_err));
    chk({nm, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    int base;
    int t;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_ptr_ready", 32'(ptr_ready), 0);
    chk("rst_ent_ready", 32'(ent_ready), 0);
    rst = 1'b0;

    // All-zero frame
    clear_frame();
    ready_cnt = 0;
    run_frame("zero", 1'b0, N * N);
    chk("zero_ent_ready_never", ready_cnt, 0);

    // Sparse frame: row 0 holds (3,0x11) and (27,0x22)
    clear_frame();
    for (int i = 1; i <= N; i++) pv[i] = 2;
    ecol = '{3, 27};
    eval = '{8'h11, 8'h22};
    img[0][3]  = 8'h11;
    img[0][27] = 8'h22;
    run_frame("sparse", 1'b0, N * N);

    // Same frame with a 5-cycle entry gap before the second entry
    stall_idx = 1;
    run_frame("stall", 1'b0, N * N + 5);

    // Out-of-range column is consumed as an error, pixel stays 0
    clear_frame();
    for (int i = 1; i <= N; i++) pv[i] = 1;
    ecol = '{30};
    eval = '{8'h55};
    run_frame("badcol", 1'b1, N * N);
    repeat (3) @(negedge clk);
    chk("badcol_err_sticky", 32'(err), 1);

    // ptr[0] != 0
    clear_frame();
    for (int i = 0; i <= N; i++) pv[i] = 1;
    ecol = '{0};
    eval = '{8'h05};
    img[0][0] = 8'h05;
    run_frame("ptr0", 1'b1, N * N);

    // ptr[5] < ptr[4]; row 3 carries two entries
    clear_frame();
    pv[4] = 2;
    pv[5] = 1;
    for (int i = 6; i <= N; i++) pv[i] = 2;
    ecol = '{5, 9};
    eval = '{8'h33, 8'h44};
    img[3][5] = 8'h33;
    img[3][9] = 8'h44;
    run_frame("ptr_dec", 1'b1, N * N);

    // Entry count short of ptr[28] at frame end
    clear_frame();
    pv[N] = 2;
    ecol = '{27};
    eval = '{8'h77};
    img[27][27] = 8'h77;
    run_frame("unconsumed", 1'b1, N * N);

    // Next clean frame clears err
    clear_frame();
    run_frame("zero2", 1'b0, N * N);

    // Reset at about pixel 100 of a frame
    clear_frame();
    push_expect();
    exp_span = N * N;
    base = pix_cnt;
    pulse_start();
    load_ptrs();
    t = 0;
    while (pix_cnt < base + 100 && t < 1000) begin @(negedge clk); t++; end
    chk("midrst_reached_100", 32'(pix_cnt - base >= 100), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_data_out", 32'(data_out), 0);
    chk("midrst_out_row", 32'(out_row), 0);
    chk("midrst_done", 32'(done), 0);
    exp_q.delete();
    first_cyc = -1;
    @(posedge clk);
    #3;
    rst = 1'b0;

    clear_frame();
    for (int i = 1; i <= N; i++) pv[i] = 2;
    ecol = '{3, 27};
    eval = '{8'h11, 8'h22};
    img[0][3]  = 8'h11;
    img[0][27] = 8'h22;
    run_frame("after_rst", 1'b0, N * N);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_decoder.md
Name: csr_decoder

Overview:
- Inverse of the CSR encoder: rebuilds a dense image_size x image_size feature map from a CSR description.
- Inputs are a row-pointer stream and a (column, value) non-zero entry stream.
- Output is one dense pixel per cycle in raster order, with zero fill.
- Used to check encoder output in-system and to feed dense consumers from compressed storage.

Parameters:
- word_length, 8, pixel/value width
- double_word_length, 16, row-pointer width (must hold image_size*image_size)
- col_length, 8, column index width
- image_size, 28, image edge length

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a frame when idle
- ptr_valid  in  1  row pointer present on ptr_data
- ptr_ready  out  1  decoder accepts pointer
- ptr_data  in  double_word_length  CSR row pointer
- ent_valid  in  1  entry present
- ent_ready  out  1  entry consumed this cycle
- ent_col  in  col_length  column of non-zero
- ent_value  in  word_length  value of non-zero
- out_valid  out  1  data_out holds a pixel
- data_out  out  word_length  dense pixel
- out_row  out  col_length  row of data_out
- out_col  out  col_length  column of data_out
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse with last pixel
- err  out  1  sticky protocol error, cleared by start

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; counters, pointer RAM index and err cleared. Reset mid-frame aborts the frame; no further pixels are emitted.
- States: IDLE, LOAD_PTR, DECODE.
- IDLE:
  - start=1 -> LOAD_PTR; err cleared; pointer index p=0.
  - ptr/ent inputs ignored; ptr_ready=ent_ready=0.
- LOAD_PTR:
  - ptr_ready=1.
  - On ptr_valid, store ptr[p]=ptr_data and increment p.
  - After image_size+1 pointers -> DECODE with row=0, col=0, k=0 (k = entries consumed).
  - err is set if ptr[0]!=0, if ptr[p]<ptr[p-1], or if ptr[image_size]>image_size*image_size. Loading continues regardless.
- DECODE, one decision per cycle:
  - pending = (k < ptr[row+1]).
  - not pending: emit 0.
  - pending & !ent_valid: stall; no pixel, counters hold, out_valid=0 next cycle.
  - pending & ent_valid & ent_col==col: emit ent_value; ent_ready=1; k+1.
  - pending & ent_valid & col<ent_col<image_size: emit 0; entry not consumed.
  - pending & ent_valid & (ent_col<col or ent_col>=image_size): consume; emit 0; err=1.
  - ent_ready is combinational and asserted only in the consume cases.
- Emission timing:
  - data_out, out_row, out_col and out_valid are registered: a pixel decided in cycle t appears in cycle t+1.
  - Each emission advances col; col wraps image_size-1 -> 0 and row increments.
- Frame end:
  - After deciding pixel (image_size-1, image_size-1) -> IDLE.
  - done=1 together with that pixel's out_valid.
  - If k != ptr[image_size] at that point, err=1 on the same cycle.
  - With no stalls a frame is exactly image_size*image_size consecutive out_valid cycles.
- Non-pending rows emit zeros without looking at ent_valid.
- start outside IDLE is ignored. A start in the cycle after done is accepted.
- Arithmetic: all comparisons are unsigned; k and ptr use double_word_length bits; no wrap occurs for legal frames.

Test Plan:
- All-zero frame: 29 pointers = 0 -> 784 consecutive zero pixels, done with pixel (27,27), err=0, ent_ready never 1.
- Sparse frame: ptr[0]=0, ptr[1..28]=2, entries (3,0x11),(27,0x22) -> row 0 col 3=0x11, col 27=0x22, all else 0; done after 784 pixels; err=0.
- Stall: same frame with ent_valid low 5 cycles before the second entry -> out_valid gap of 5 cycles, identical pixel sequence, done after 789 cycles of DECODE.
- Bad column: row 0 count 1, entry col=30 -> entry consumed, pixel 0, err=1 held until next start; frame still completes.
- Pointer errors: ptr[0]=1 -> err=1; separately ptr[5]<ptr[4] -> err=1; separately entries left unconsumed at end -> err=1 with done.
- Reset mid-DECODE at pixel 100 -> outputs 0 immediately, busy=0; a new start then yields a correct full 784-pixel frame.
